// File: rtl/mem_size_pkg.sv
// Purpose : shared encodings for the sized load/store controller (ops, reduce sizes, FSM states).
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package mem_size_pkg;

  typedef enum logic [2:0] {
    OP_LW = 3'b000,
    OP_LH = 3'b001,
    OP_LB = 3'b010,
    OP_SW = 3'b100,
    OP_SH = 3'b101,
    OP_SB = 3'b110
  } memOp_e;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10
  } rdcSize_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_LATCH,
    S_MERGE_WR,
    S_WR,
    S_FINISH,
    S_ERR
  } state_e;

  function automatic logic isStore(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Reduce-mux size for an op; word for anything that is not a half/byte access.
  function automatic rdcSize_e opSize(input logic [2:0] op);
    case (op)
      OP_LH, OP_SH: return SIZE_HALF;
      OP_LB, OP_SB: return SIZE_BYTE;
      default:      return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Purpose : flags illegal op codes and misaligned word/half addresses.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : op[2:0], addr_lo[1:0] in; misalign, illegal out.
module mem_align_chk
  import mem_size_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  output logic       misalign,
  output logic       illegal
);

  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_LW, OP_SW: misalign = (addr_lo != 2'b00);
      OP_LH, OP_SH: misalign = addr_lo[0];
      OP_LB, OP_SB: misalign = 1'b0;
      default:      illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_size_ctrl.sv
// Purpose : sequences sized loads, read-modify-write sub-word stores and word stores.
// Latency : start->done LW/LH/LB 4, SH/SB 5, SW 2, error 1 cycle(s).
// Backpressure: start is only sampled in IDLE; busy=1 means start is ignored.
// Ports   : clk, reset (sync, active-high), start, op[2:0], addr_lo[1:0] in;
//           MemWR, MemRd, MDRWrite, RdcCtrl, RdcSize[1:0], RegWrLd, busy, done, err out.
module mem_size_ctrl
  import mem_size_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  output logic       MemWR,
  output logic       MemRd,
  output logic       MDRWrite,
  output logic       RdcCtrl,
  output logic [1:0] RdcSize,
  output logic       RegWrLd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     stateQ, stateD;
  logic [2:0] opQ;
  logic [1:0] addrLoQ;

  logic [2:0] chkOp;
  logic [1:0] chkAddrLo;
  logic       chkMisalign, chkIllegal;

  // In IDLE the checker judges the incoming request; once in flight it watches
  // the captured operands, which must stay legal for the whole operation.
  assign chkOp     = (stateQ == S_IDLE) ? op      : opQ;
  assign chkAddrLo = (stateQ == S_IDLE) ? addr_lo : addrLoQ;

  mem_align_chk uAlignChk (
    .op       (chkOp),
    .addr_lo  (chkAddrLo),
    .misalign (chkMisalign),
    .illegal  (chkIllegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= S_IDLE;
      opQ     <= '0;
      addrLoQ <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == S_IDLE && start) begin
        opQ     <= op;
        addrLoQ <= addr_lo;
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          if (chkIllegal || chkMisalign) stateD = S_ERR;
          else if (op == OP_SW)          stateD = S_WR;
          else                           stateD = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: stateD = S_RD_WAIT;
      S_RD_WAIT:  stateD = S_LATCH;
      // Sub-word stores merge into the word just read; loads are done.
      S_LATCH:    stateD = isStore(opQ) ? S_MERGE_WR : S_FINISH;
      S_MERGE_WR: stateD = S_FINISH;
      S_WR:       stateD = S_FINISH;
      S_FINISH:   stateD = S_IDLE;
      S_ERR:      stateD = S_IDLE;
      default:    stateD = S_IDLE;
    endcase
  end

  always_comb begin
    MemWR    = 1'b0;
    MemRd    = 1'b0;
    MDRWrite = 1'b0;
    RdcCtrl  = 1'b0;
    RdcSize  = SIZE_WORD;
    RegWrLd  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (stateQ != S_IDLE);
    case (stateQ)
      S_RD_ISSUE: MemRd    = 1'b1;
      S_LATCH:    MDRWrite = 1'b1;
      S_MERGE_WR: begin
        RdcCtrl = 1'b1;
        MemWR   = 1'b1;
        RdcSize = opSize(opQ);
      end
      S_WR: begin
        RdcCtrl = 1'b1;
        MemWR   = 1'b1;
        RdcSize = SIZE_WORD;
      end
      S_FINISH: begin
        done = 1'b1;
        if (!isStore(opQ)) begin
          RegWrLd = 1'b1;
          RdcSize = opSize(opQ);
        end
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
    // Reset kills side effects in the same cycle so an interrupted RMW never writes.
    if (reset) begin
      MemWR    = 1'b0;
      MemRd    = 1'b0;
      MDRWrite = 1'b0;
      RegWrLd  = 1'b0;
    end
  end

  inFlightLegal: assert property (@(posedge clk) disable iff (reset)
    (stateQ != S_IDLE && stateQ != S_ERR) |-> !(chkMisalign || chkIllegal));

endmodule

// File: tb/tb_mem_size_ctrl.sv
module tb_mem_size_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [2:0] op;
  logic [1:0] addrLo;
  logic       MemWR, MemRd, MDRWrite, RdcCtrl, RegWrLd, busy, done, err;
  logic [1:0] RdcSize;

  mem_size_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .addr_lo  (addrLo),
    .MemWR    (MemWR),
    .MemRd    (MemRd),
    .MDRWrite (MDRWrite),
    .RdcCtrl  (RdcCtrl),
    .RdcSize  (RdcSize),
    .RegWrLd  (RegWrLd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memWr;
    logic       memRd;
    logic       mdrWrite;
    logic       rdcCtrl;
    logic [1:0] rdcSize;
    logic       regWrLd;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: an accepted request becomes a list of per-cycle output sets,
  // derived from access size, direction and alignment.
  outs_t built[$];

  function automatic void buildSched(input logic [2:0] o, input logic [1:0] a);
    outs_t steps[5];
    int    nBytes, n;
    bit    bad, store;
    logic [1:0] sz;
    sz     = o[1:0];
    store  = o[2];
    nBytes = 4 >> sz;
    if (sz == 2'b11) bad = 1'b1;
    else             bad = (int'(a) % nBytes) != 0;
    for (int i = 0; i < 5; i++) begin
      steps[i]      = '0;
      steps[i].busy = 1'b1;
    end
    if (bad) begin
      n = 1;
      steps[0].done = 1'b1;
      steps[0].err  = 1'b1;
    end else if (store && sz == 2'b00) begin
      n = 2;
      steps[0].memWr   = 1'b1;
      steps[0].rdcCtrl = 1'b1;
      steps[1].done    = 1'b1;
    end else begin
      steps[0].memRd    = 1'b1;
      steps[2].mdrWrite = 1'b1;
      if (store) begin
        n = 5;
        steps[3].memWr   = 1'b1;
        steps[3].rdcCtrl = 1'b1;
        steps[3].rdcSize = sz;
        steps[4].done    = 1'b1;
      end else begin
        n = 4;
        steps[3].done    = 1'b1;
        steps[3].regWrLd = 1'b1;
        steps[3].rdcSize = sz;
      end
    end
    built.delete();
    for (int i = 0; i < n; i++) built.push_back(steps[i]);
  endfunction

  outs_t cur = '0;
  outs_t sched[$];
  bit    modelOn = 1'b0;

  // Model advance on the edge, compare shortly after it, every cycle.
  always @(posedge clk) begin
    outs_t expv, act;
    if (reset) begin
      sched.delete();
      cur     = '0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      if (!cur.busy && start) begin
        buildSched(op, addrLo);
        sched = built;
        cur   = sched.pop_front();
      end else if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else begin
        cur = '0;
      end
    end
    #1;
    if (modelOn) begin
      expv = cur;
      if (reset) begin
        expv.memWr    = 1'b0;
        expv.memRd    = 1'b0;
        expv.mdrWrite = 1'b0;
        expv.regWrLd  = 1'b0;
      end
      act = {MemWR, MemRd, MDRWrite, RdcCtrl, RdcSize, RegWrLd, busy, done, err};
      testsRun++;
      if (act !== expv) begin
        testsFailed++;
        $display("FAIL cycle_cmp t=%0t got %b expected %b", $time, act, expv);
      end
      testsRun++;
      if (MemWR === 1'b1 && MemRd === 1'b1) begin
        testsFailed++;
        $display("FAIL rd_wr_exclusive t=%0t got MemWR=1 MemRd=1 expected not both", $time);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [1:0] a);
    start  = 1'b1;
    op     = o;
    addrLo = a;
    @(negedge clk);
    start  = 1'b0;
    op     = 3'($urandom_range(0, 7));
    addrLo = 2'($urandom_range(0, 3));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'b000;
    addrLo = 2'b00;

    // Pin the reference model with hand-derived values.
    buildSched(3'b000, 2'b00);
    chk("model_lw_len", built.size(), 4);
    buildSched(3'b101, 2'b10);
    chk("model_sh_len", built.size(), 5);
    chk("model_sh_c4", built[3], 10'b1001010100);
    buildSched(3'b100, 2'b00);
    chk("model_sw_len", built.size(), 2);
    buildSched(3'b100, 2'b01);
    chk("model_sw_mis_len", built.size(), 1);
    buildSched(3'b111, 2'b00);
    chk("model_illegal_len", built.size(), 1);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdcctrl", RdcCtrl, 0);
    chk("rst_rdcsize", RdcSize, 0);
    chk("rst_memwr", MemWR, 0);
    chk("rst_memrd", MemRd, 0);

    // LB at addr 3
    issue(3'b010, 2'b11);
    chk("lb_memrd_c1", MemRd, 1);
    repeat (2) @(negedge clk);
    chk("lb_mdr_c3", MDRWrite, 1);
    @(negedge clk);
    chk("lb_done_c4", done, 1);
    chk("lb_regwr_c4", RegWrLd, 1);
    chk("lb_size_c4", RdcSize, 2);
    chk("lb_ctrl_c4", RdcCtrl, 0);
    @(negedge clk);
    chk("lb_idle_c5", busy, 0);

    // SH at addr 2 (read-modify-write)
    issue(3'b101, 2'b10);
    chk("sh_memrd_c1", MemRd, 1);
    repeat (3) @(negedge clk);
    chk("sh_memwr_c4", MemWR, 1);
    chk("sh_ctrl_c4", RdcCtrl, 1);
    chk("sh_size_c4", RdcSize, 1);
    chk("sh_nodone_c4", done, 0);
    @(negedge clk);
    chk("sh_done_c5", done, 1);
    chk("sh_noregwr_c5", RegWrLd, 0);
    @(negedge clk);

    // Misaligned SW
    issue(3'b100, 2'b01);
    chk("swmis_err_c1", err, 1);
    chk("swmis_done_c1", done, 1);
    chk("swmis_memwr_c1", MemWR, 0);
    chk("swmis_memrd_c1", MemRd, 0);
    @(negedge clk);
    chk("swmis_idle_c2", busy, 0);

    // Illegal op, then an LW straight after
    issue(3'b011, 2'b00);
    chk("ill_err_c1", err, 1);
    @(negedge clk);
    chk("ill_idle_c2", busy, 0);
    issue(3'b000, 2'b00);
    chk("lw_memrd_c1", MemRd, 1);
    repeat (3) @(negedge clk);
    chk("lw_done_c4", done, 1);
    chk("lw_size_c4", RdcSize, 0);
    @(negedge clk);

    // SB interrupted by reset during the merge write
    issue(3'b110, 2'b01);
    repeat (3) @(negedge clk);
    chk("sb_memwr_c4", MemWR, 1);
    reset = 1'b1;
    #1;
    chk("sb_rst_memwr", MemWR, 0);
    @(negedge clk);
    chk("sb_rst_busy", busy, 0);
    chk("sb_rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // start held high through an LW
    start  = 1'b1;
    op     = 3'b000;
    addrLo = 2'b00;
    @(negedge clk);
    chk("hold_memrd_c1", MemRd, 1);
    repeat (3) @(negedge clk);
    chk("hold_done_c4", done, 1);
    @(negedge clk);
    chk("hold_idle_c5", busy, 0);
    @(negedge clk);
    chk("hold_memrd_c6", MemRd, 1);
    chk("hold_busy_c6", busy, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_done_c9", done, 1);
    @(negedge clk);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      addrLo = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_size_ctrl.md
MEM_SIZE_CTRL -- requirements
Module: mem_size_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; other codes illegal
- addr_lo  in  2  effective address bits [1:0]
- MemWR  out  1  1 = memory write, 0 = read
- MemRd  out  1  1 = issue memory read this cycle
- MDRWrite  out  1  load MDR from memory output
- RdcCtrl  out  1  reduce-mux select: 0 = MDR, 1 = B
- RdcSize  out  2  00 word, 01 half, 10 byte
- RegWrLd  out  1  write reduced load result to register file
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on misaligned or illegal op

Function
REQ-003 SHALL capture op and addr_lo into internal registers on the edge where start=1 in IDLE; later changes to op and addr_lo SHALL NOT affect the operation in flight.
REQ-004 SHALL ignore start while busy=1.
REQ-005 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, LATCH, MERGE_WR, WR, FINISH, ERR.
REQ-006 IDLE transitions:
- start with an illegal op, or with misalignment (LW/SW and addr_lo!=00; LH/SH and addr_lo[0]=1) -> ERR
- start with SW -> WR
- start with any other legal op -> RD_ISSUE
REQ-007 Load path SHALL be RD_ISSUE -> RD_WAIT -> LATCH -> FINISH -> IDLE; memory read latency is fixed at one cycle.
REQ-008 SH/SB path SHALL be RD_ISSUE -> RD_WAIT -> LATCH -> MERGE_WR -> FINISH -> IDLE (read-modify-write).
REQ-009 SW path SHALL be WR -> FINISH -> IDLE.
REQ-010 ERR SHALL last one cycle, assert done=1 and err=1, issue no memory access, then return to IDLE.
REQ-011 Outputs SHALL be Moore, decoded from the state register and the captured op:
- RD_ISSUE: MemRd=1
- LATCH: MDRWrite=1
- MERGE_WR: RdcCtrl=1, MemWR=1, RdcSize from op
- WR: RdcCtrl=1, MemWR=1, RdcSize=00
- FINISH: done=1; for loads also RdcCtrl=0, RegWrLd=1, RdcSize from op
REQ-012 All outputs not listed for a state SHALL be 0.
REQ-013 Latency from the start edge to the done pulse SHALL be: LW/LH/LB 4 cycles, SH/SB 5, SW 2, ERR 1.
REQ-014 MemWR and MemRd SHALL never be high in the same cycle.
REQ-015 A new start SHALL be accepted in the cycle after FINISH or ERR (IDLE), with no bubble beyond that.

Reset
REQ-016 When reset=1 at a rising edge, SHALL enter IDLE and clear the captured op and addr_lo to 0.
REQ-017 In any cycle where reset=1, SHALL force MemWR, MemRd, MDRWrite and RegWrLd to 0, including mid-operation; no partial write SHALL reach memory.
REQ-018 After reset: busy=0, done=0, err=0, RdcCtrl=0, RdcSize=00.

Structure
REQ-019 Op encodings, RdcSize encodings and the state enumeration SHALL live in shared package mem_size_pkg.
REQ-020 Alignment and legality checking SHALL be a sub-module mem_align_chk: inputs op and addr_lo, outputs misalign and illegal; purely combinational.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- LB, addr_lo=11: MemRd at cycle 1, MDRWrite at cycle 3, done/RegWrLd at cycle 4 with RdcSize=10 and RdcCtrl=0.
- SH, addr_lo=10: read at cycle 1, MemWR=1 with RdcCtrl=1 and RdcSize=01 at cycle 4, done at cycle 5.
- SW, addr_lo=01: err=done=1 at cycle 1; MemWR and MemRd stay 0 throughout.
- op=011 (illegal): err pulse; a following LW start is accepted next cycle and completes at 4.
- Reset asserted during MERGE_WR of SB: MemWR=0 in that cycle; IDLE and busy=0 on the next cycle.
- start held high through an LW: exactly one operation, then a second one starts from IDLE; MemRd and MemWR never high together.
